// File: rtl/ariane_dfx_ctrl.sv
// ariane_dfx_ctrl: initiator side of the DFX shutdown/decouple/reset handshake for the Ariane partition.
module ariane_dfx_ctrl #(
  parameter int unsigned AckTimeout  = 1024,
  parameter int unsigned ResetCycles = 16,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reconfig_req_i,
  input  logic                  reconfig_done_i,
  input  logic                  shutdown_ack_i,
  output logic                  shutdown_req_o,
  output logic                  dfx_decouple_o,
  output logic                  rp_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [CountWidth-1:0] reconfig_count_o
);
  localparam int unsigned MaxCycles = (AckTimeout > ResetCycles) ? AckTimeout : ResetCycles;
  localparam int unsigned CntW = $clog2(MaxCycles);
  localparam logic [CntW-1:0] AckLast = CntW'(AckTimeout - 1);
  localparam logic [CntW-1:0] RstLast = CntW'(ResetCycles - 1);
  typedef enum logic [1:0] {IDLE, SHUTDOWN, ISOLATE, RESET} state_e;
  state_e r_state, w_state_n;
  logic [CntW-1:0] r_cnt, w_cnt_n;
  logic w_timeout_n, w_done_n;
  logic [CountWidth-1:0] w_count_n;
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_timeout_n = timeout_o;
    w_done_n    = 1'b0;
    w_count_n   = reconfig_count_o;
    case (r_state)
      IDLE: if (reconfig_req_i) begin
        w_state_n   = SHUTDOWN;
        w_timeout_n = 1'b0;
        w_cnt_n     = '0;
      end
      SHUTDOWN: begin
        w_cnt_n = r_cnt + 1'b1;
        if (shutdown_ack_i) w_state_n = ISOLATE;
        else if (r_cnt == AckLast) begin
          w_state_n   = ISOLATE;
          w_timeout_n = 1'b1;
        end
      end
      ISOLATE: if (reconfig_done_i) begin
        w_state_n = RESET;
        w_cnt_n   = '0;
      end
      default: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_cnt == RstLast) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
          w_count_n = reconfig_count_o + 1'b1;
        end
      end
    endcase
  end
  // Outputs are decoded from the next state so they stay registered yet switch on the deciding edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      shutdown_req_o   <= 1'b0;
      dfx_decouple_o   <= 1'b0;
      rp_reset_o       <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      timeout_o        <= 1'b0;
      reconfig_count_o <= '0;
    end else begin
      r_state          <= w_state_n;
      r_cnt            <= w_cnt_n;
      shutdown_req_o   <= w_state_n == SHUTDOWN;
      dfx_decouple_o   <= w_state_n == ISOLATE;
      rp_reset_o       <= w_state_n == ISOLATE || w_state_n == RESET;
      busy_o           <= w_state_n != IDLE;
      done_o           <= w_done_n;
      timeout_o        <= w_timeout_n;
      reconfig_count_o <= w_count_n;
    end
  end
endmodule

// File: tb/tb_ariane_dfx_ctrl.sv
// tb_ariane_dfx_ctrl: directed scenarios plus randomized traffic against an event-timestamp model of the handshake.
module tb_ariane_dfx_ctrl;
  localparam int unsigned AckTimeout = 8, ResetCycles = 4, CountWidth = 2;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, ack = 1'b0, dn = 1'b0;
  logic shutdown_req, decouple, rp_reset, busy, done, timeout;
  logic [CountWidth-1:0] count;
  int errors = 0, checks = 0;
  ariane_dfx_ctrl #(.AckTimeout(AckTimeout), .ResetCycles(ResetCycles), .CountWidth(CountWidth)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reconfig_req_i(req), .reconfig_done_i(dn), .shutdown_ack_i(ack),
    .shutdown_req_o(shutdown_req), .dfx_decouple_o(decouple), .rp_reset_o(rp_reset), .busy_o(busy),
    .done_o(done), .timeout_o(timeout), .reconfig_count_o(count)
  );
  always #5 clk = ~clk;
  // Model: a sequence is described by when it started, whether the core is isolated and when the bitstream finished.
  bit active, iso, rel, m_timeout, m_done;
  int e, t_start, t_rel, m_count;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 0; iso = 0; rel = 0; m_timeout = 0; m_done = 0; m_count = 0; e = 0;
    end else begin
      e = e + 1;
      m_done = 0;
      if (!active) begin
        if (req) begin active = 1; iso = 0; rel = 0; t_start = e; m_timeout = 0; end
      end else if (!iso) begin
        if (ack) iso = 1;
        else if (e - t_start == AckTimeout) begin iso = 1; m_timeout = 1; end
      end else if (!rel) begin
        if (dn) begin rel = 1; t_rel = e; end
      end else if (e == t_rel + ResetCycles) begin
        active = 0; m_done = 1; m_count = (m_count + 1) % (1 << CountWidth);
      end
    end
  end
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cmp("m_shutdown_req", 32'(shutdown_req), 32'(active && !iso));
    cmp("m_decouple", 32'(decouple), 32'(active && iso && !rel));
    cmp("m_rp_reset", 32'(rp_reset), 32'(active && iso));
    cmp("m_busy", 32'(busy), 32'(active));
    cmp("m_done", 32'(done), 32'(m_done));
    cmp("m_timeout", 32'(timeout), 32'(m_timeout));
    cmp("m_count", 32'(count), 32'(m_count));
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run_seq;
    req = 1; tick(1); req = 0;
    tick(2);
    ack = 1; tick(1); ack = 0;
    tick(1);
    dn = 1; tick(1); dn = 0;
    tick(ResetCycles);
    cmp("seq_done_pulse", 32'(done), 1);
    tick(1);
  endtask
  initial begin
    int ackp;
    #2;
    cmp("reset_busy", 32'(busy), 0);
    cmp("reset_outputs", {26'd0, shutdown_req, decouple, rp_reset, done, timeout, 1'b0}, 0);
    tick(1);
    rst_n = 1;
    tick(2);
    // Nominal: request edge 0, ack edge 3, done edge 10.
    req = 1; tick(1); req = 0;
    cmp("nom_req_c1", 32'(shutdown_req), 1);
    tick(2);
    ack = 1; tick(1); ack = 0;
    cmp("nom_req_fall", 32'(shutdown_req), 0);
    cmp("nom_decouple_c4", 32'(decouple), 1);
    cmp("nom_rst_c4", 32'(rp_reset), 1);
    tick(6);
    dn = 1; tick(1); dn = 0;
    cmp("nom_decouple_c11", 32'(decouple), 0);
    cmp("nom_rst_c11", 32'(rp_reset), 1);
    tick(3);
    cmp("nom_rst_c14", 32'(rp_reset), 1);
    tick(1);
    cmp("nom_rst_c15", 32'(rp_reset), 0);
    cmp("nom_done_c15", 32'(done), 1);
    cmp("nom_count", 32'(count), 1);
    tick(1);
    cmp("nom_done_c16", 32'(done), 0);
    // Ack timeout.
    req = 1; tick(1); req = 0;
    tick(7);
    cmp("to_not_yet", 32'(decouple), 0);
    cmp("to_flag_early", 32'(timeout), 0);
    tick(1);
    cmp("to_isolate", 32'(decouple), 1);
    cmp("to_flag", 32'(timeout), 1);
    dn = 1; tick(1); dn = 0;
    tick(ResetCycles + 3);
    cmp("to_sticky", 32'(timeout), 1);
    req = 1; tick(1); req = 0;
    cmp("to_cleared", 32'(timeout), 0);
    ack = 1; tick(1); ack = 0;
    dn = 1; tick(1); dn = 0;
    tick(ResetCycles + 1);
    // Ack coincident with the timeout edge.
    req = 1; tick(1); req = 0;
    tick(AckTimeout - 1);
    ack = 1; tick(1); ack = 0;
    cmp("co_isolate", 32'(decouple), 1);
    cmp("co_no_flag", 32'(timeout), 0);
    dn = 1; tick(1); dn = 0;
    tick(ResetCycles + 1);
    // Spurious inputs.
    dn = 1; tick(1); dn = 0;
    cmp("sp_idle_done", 32'(busy), 0);
    req = 1; tick(1); req = 0;
    dn = 1; tick(1); dn = 0;
    cmp("sp_shut_done_req", 32'(shutdown_req), 1);
    cmp("sp_shut_done_dec", 32'(decouple), 0);
    ack = 1; tick(1); ack = 0;
    req = 1; tick(1); req = 0;
    cmp("sp_iso_req", 32'(decouple), 1);
    dn = 1; tick(1); dn = 0;
    tick(ResetCycles + 1);
    cmp("sp_no_extra", 32'(busy), 0);
    tick(2);
    cmp("sp_no_extra2", 32'(busy), 0);
    // Async reset while isolated.
    req = 1; tick(1); req = 0;
    ack = 1; tick(1); ack = 0;
    #2 rst_n = 0;
    #1;
    cmp("ar_outputs", {27'd0, shutdown_req, decouple, rp_reset, busy, timeout}, 0);
    cmp("ar_count", 32'(count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1;
    tick(1);
    cmp("ar_idle", 32'(busy), 0);
    // Counter wrap with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      run_seq();
      cmp("wrap_count", 32'(count), (i + 1) % 4);
    end
    // Randomized traffic.
    ackp = 25;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) ackp = (ackp == 0) ? 25 : 0;
      req = $urandom_range(0, 99) < 30;
      ack = $urandom_range(0, 99) < ackp;
      dn  = $urandom_range(0, 99) < 15;
      rst_n = $urandom_range(0, 199) != 0;
      tick(1);
    end
    rst_n = 1; req = 0; ack = 0; dn = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
